// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a shared block memory, with busy timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: data wins).
module mem_arbiter #(
  parameter int blocksize = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic                      i_valid,
  output logic [blocksize*32-1:0]   i_rd,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wd,
  output logic                      d_valid,
  output logic [blocksize*32-1:0]   d_rd,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [31:0]               mem_a,
  output logic [31:0]               mem_wd,
  input  logic [blocksize*32-1:0]   mem_rd,
  input  logic                      mem_valid,
  output logic                      err
);

  localparam int             BW       = blocksize * 32;
  localparam logic [7:0]     LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] wd_r;
  logic        we_r;
  logic [7:0]  cnt_r;
  logic        err_r;
  logic        grant_d_s;
  logic        load_s;
  logic        abort_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_r;  // 1'b0 = instruction side, 1'b1 = data side

  // Winner selection: on a tie, grant the side that did not win last time
  always_comb begin
    if (i_req && d_req) begin
      grant_d_s = ~last_grant_r;
    end else begin
      grant_d_s = d_req;
    end
  end

  // Remember which side won the most recent grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b0;
    end else if (load_s) begin
      last_grant_r <= grant_d_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Winner selection: data side always wins a tie
  always_comb begin
    grant_d_s = d_req;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: grant from IDLE, leave BUSY on completion or timeout
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req || d_req) begin
          load_s      = 1'b1;
          state_nxt_s = grant_d_s ? BUSY_D : BUSY_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // Completion on the last allowed cycle takes precedence over the abort
        if (mem_valid) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Latched request, busy counter and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r <= 32'd0;
      wd_r   <= 32'd0;
      we_r   <= 1'b0;
      cnt_r  <= 8'd0;
      err_r  <= 1'b0;
    end else begin
      err_r <= abort_s;
      if (load_s) begin
        cnt_r <= 8'd0;
        if (grant_d_s) begin
          addr_r <= d_addr;
          wd_r   <= d_wd;
          we_r   <= d_we;
        end else begin
          addr_r <= i_addr;
          wd_r   <= 32'd0;
          we_r   <= 1'b0;
        end
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Memory-side drive and requester responses, decoded from state and latched data
  always_comb begin
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    mem_a   = 32'd0;
    mem_wd  = 32'd0;
    i_valid = 1'b0;
    d_valid = 1'b0;
    i_rd    = {BW{1'b0}};
    d_rd    = {BW{1'b0}};
    case (state_r)
      BUSY_I: begin
        mem_re  = 1'b1;
        mem_a   = addr_r;
        i_valid = mem_valid;
        if (mem_valid) begin
          i_rd = mem_rd;
        end else begin
          i_rd = {BW{1'b0}};
        end
      end
      BUSY_D: begin
        mem_re  = ~we_r;
        mem_we  = we_r;
        mem_a   = addr_r;
        mem_wd  = wd_r;
        d_valid = mem_valid;
        if (mem_valid) begin
          d_rd = mem_rd;
        end else begin
          d_rd = {BW{1'b0}};
        end
      end
      default: begin
        mem_re = 1'b0;
      end
    endcase
  end

  assign err = err_r;

endmodule
